// File: rtl/iso_line_raster_pkg.sv
// Shared types and screen geometry for the isometric line rasteriser.
// Holds projected/screen coordinate types, the raster FSM states and small helpers.
package iso_pkg;

    localparam int COORD_W = 10;
    localparam int SCR_W   = 640;
    localparam int SCR_H   = 480;
    localparam int X_OFF   = 320;
    localparam int Y_OFF   = 240;
    localparam int COLOR_W = 8;
    localparam int PIX_W   = 10;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [11:0]        scr_t;
    typedef logic signed [12:0]        err_t;
    typedef logic [COLOR_W-1:0]        color_t;
    typedef logic [PIX_W-1:0]          pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } raster_state_t;

    localparam scr_t X_OFF_S = scr_t'(X_OFF);
    localparam scr_t Y_OFF_S = scr_t'(Y_OFF);
    localparam scr_t SCR_W_S = scr_t'(SCR_W);
    localparam scr_t SCR_H_S = scr_t'(SCR_H);

    function automatic scr_t abs_scr(input scr_t v);
        if (v < 12'sd0) begin
            abs_scr = -v;
        end else begin
            abs_scr = v;
        end
    endfunction

    function automatic logic on_screen(input scr_t x, input scr_t y);
        on_screen = (x >= 12'sd0) && (x < SCR_W_S) && (y >= 12'sd0) && (y < SCR_H_S);
    endfunction

endpackage

// File: rtl/iso_line_raster_if.sv
// Segment request and pixel-write bus of the line rasteriser.
// slave = rasteriser side, master = the side issuing segments and sinking pixels.
interface iso_line_raster_if;
    import iso_pkg::*;

    logic   line_valid_i;
    logic   line_ready_o;
    coord_t x0_i;
    coord_t y0_i;
    coord_t x1_i;
    coord_t y1_i;
    color_t color_i;
    logic   pix_valid_o;
    logic   pix_ready_i;
    pix_t   pix_x_o;
    pix_t   pix_y_o;
    color_t pix_color_o;
    logic   busy_o;
    logic   done_o;

    modport slave (
        input  line_valid_i, x0_i, y0_i, x1_i, y1_i, color_i, pix_ready_i,
        output line_ready_o, pix_valid_o, pix_x_o, pix_y_o, pix_color_o, busy_o, done_o
    );

    modport master (
        output line_valid_i, x0_i, y0_i, x1_i, y1_i, color_i, pix_ready_i,
        input  line_ready_o, pix_valid_o, pix_x_o, pix_y_o, pix_color_o, busy_o, done_o
    );

endinterface

// File: rtl/iso_line_raster_bres_step.sv
// One combinational Bresenham step: next point, next error term and last-point flag.
module bres_step
    import iso_pkg::*;
(
    input  scr_t cx,
    input  scr_t cy,
    input  err_t err,
    input  scr_t dx,
    input  scr_t dy,
    input  scr_t stx,
    input  scr_t sty,
    input  scr_t ex,
    input  scr_t ey,
    output scr_t cx_nxt,
    output scr_t cy_nxt,
    output err_t err_nxt,
    output logic last
);

    logic signed [13:0] e2_s;
    logic signed [13:0] dx_w_s;
    logic signed [13:0] dy_w_s;
    err_t               err_x_s;
    err_t               err_y_s;

    // Both axis decisions compare against the pre-step error term.
    always_comb begin
        e2_s    = $signed({err, 1'b0});
        dx_w_s  = $signed({{2{dx[11]}}, dx});
        dy_w_s  = $signed({{2{dy[11]}}, dy});
        last    = (cx == ex) && (cy == ey);
        cx_nxt  = cx;
        cy_nxt  = cy;
        err_x_s = 13'sd0;
        err_y_s = 13'sd0;
        if (e2_s >= dy_w_s) begin
            err_x_s = $signed({dy[11], dy});
            cx_nxt  = cx + stx;
        end else begin
            err_x_s = 13'sd0;
        end
        if (e2_s <= dx_w_s) begin
            err_y_s = $signed({dx[11], dx});
            cy_nxt  = cy + sty;
        end else begin
            err_y_s = 13'sd0;
        end
        err_nxt = err + err_x_s + err_y_s;
    end

endmodule

// File: rtl/iso_line_raster.sv
// Maps a projected 2D segment to centred screen coordinates and streams Bresenham pixels.
// Optional build macro LINE_CLIP_EN suppresses off-screen points instead of emitting them.
module iso_line_raster
    import iso_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    iso_line_raster_if.slave   bus
);

    raster_state_t state_r, state_n;

    coord_t x0_r, y0_r, x1_r, y1_r;
    scr_t   cx_r, cy_r, ex_r, ey_r, dx_r, dy_r, stx_r, sty_r;
    err_t   err_r;
    scr_t   cx_n, cy_n, ex_n, ey_n, dx_n, dy_n, stx_n, sty_n;
    err_t   err_n;

    scr_t   sx0_s, sy0_s, sx1_s, sy1_s, adx_s, ady_s;
    err_t   err_setup_s;
    scr_t   cx_step_s, cy_step_s;
    err_t   err_step_s;
    logic   last_s;
    logic   step_s;
    logic   vis_n_s;
    logic   accept_s;

    logic   line_ready_r;
    logic   pix_valid_r;
    pix_t   pix_x_r;
    pix_t   pix_y_r;
    color_t pix_color_r;
    logic   busy_r;
    logic   done_r;

    bres_step u_step (
        .cx      (cx_r),
        .cy      (cy_r),
        .err     (err_r),
        .dx      (dx_r),
        .dy      (dy_r),
        .stx     (stx_r),
        .sty     (sty_r),
        .ex      (ex_r),
        .ey      (ey_r),
        .cx_nxt  (cx_step_s),
        .cy_nxt  (cy_step_s),
        .err_nxt (err_step_s),
        .last    (last_s)
    );

    // Screen mapping of the latched endpoints; projected y grows upward, screen y downward.
    always_comb begin
        sx0_s       = scr_t'(x0_r) + X_OFF_S;
        sx1_s       = scr_t'(x1_r) + X_OFF_S;
        sy0_s       = Y_OFF_S - scr_t'(y0_r);
        sy1_s       = Y_OFF_S - scr_t'(y1_r);
        adx_s       = abs_scr(sx1_s - sx0_s);
        ady_s       = abs_scr(sy1_s - sy0_s);
        err_setup_s = err_t'(adx_s) - err_t'(ady_s);
    end

    assign accept_s = bus.line_valid_i && line_ready_r;
    // A suppressed point never waits for the writer.
    assign step_s   = pix_valid_r ? bus.pix_ready_i : 1'b1;

    // Next-state and datapath update for the raster FSM.
    always_comb begin
        state_n = state_r;
        cx_n    = cx_r;
        cy_n    = cy_r;
        err_n   = err_r;
        ex_n    = ex_r;
        ey_n    = ey_r;
        dx_n    = dx_r;
        dy_n    = dy_r;
        stx_n   = stx_r;
        sty_n   = sty_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = SETUP;
                end else begin
                    state_n = IDLE;
                end
            end
            SETUP: begin
                state_n = RUN;
                cx_n    = sx0_s;
                cy_n    = sy0_s;
                ex_n    = sx1_s;
                ey_n    = sy1_s;
                dx_n    = adx_s;
                dy_n    = -ady_s;
                err_n   = err_setup_s;
                stx_n   = (sx0_s < sx1_s) ? 12'sd1 : -12'sd1;
                sty_n   = (sy0_s < sy1_s) ? 12'sd1 : -12'sd1;
            end
            RUN: begin
                if (step_s) begin
                    if (last_s) begin
                        state_n = DONE;
                    end else begin
                        cx_n  = cx_step_s;
                        cy_n  = cy_step_s;
                        err_n = err_step_s;
                    end
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef LINE_CLIP_EN
    assign vis_n_s = on_screen(cx_n, cy_n);
`else
    assign vis_n_s = 1'b1;
`endif

    // FSM state and Bresenham datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cx_r    <= 12'sd0;
            cy_r    <= 12'sd0;
            err_r   <= 13'sd0;
            ex_r    <= 12'sd0;
            ey_r    <= 12'sd0;
            dx_r    <= 12'sd0;
            dy_r    <= 12'sd0;
            stx_r   <= 12'sd0;
            sty_r   <= 12'sd0;
        end else begin
            state_r <= state_n;
            cx_r    <= cx_n;
            cy_r    <= cy_n;
            err_r   <= err_n;
            ex_r    <= ex_n;
            ey_r    <= ey_n;
            dx_r    <= dx_n;
            dy_r    <= dy_n;
            stx_r   <= stx_n;
            sty_r   <= sty_n;
        end
    end

    // Request capture; endpoints are sampled only on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_r        <= '0;
            y0_r        <= '0;
            x1_r        <= '0;
            y1_r        <= '0;
            pix_color_r <= '0;
        end else if (accept_s) begin
            x0_r        <= bus.x0_i;
            y0_r        <= bus.y0_i;
            x1_r        <= bus.x1_i;
            y1_r        <= bus.y1_i;
            pix_color_r <= bus.color_i;
        end else begin
            x0_r        <= x0_r;
            y0_r        <= y0_r;
            x1_r        <= x1_r;
            y1_r        <= y1_r;
            pix_color_r <= pix_color_r;
        end
    end

    // Outputs are registered from the next state so they line up with the new state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_ready_r <= 1'b1;
            pix_valid_r  <= 1'b0;
            pix_x_r      <= 10'd0;
            pix_y_r      <= 10'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            line_ready_r <= (state_n == IDLE);
            busy_r       <= (state_n != IDLE);
            done_r       <= (state_n == DONE);
            pix_valid_r  <= (state_n == RUN) && vis_n_s;
            if (state_n == RUN) begin
                pix_x_r <= cx_n[PIX_W-1:0];
                pix_y_r <= cy_n[PIX_W-1:0];
            end else begin
                pix_x_r <= pix_x_r;
                pix_y_r <= pix_y_r;
            end
        end
    end

    assign bus.line_ready_o = line_ready_r;
    assign bus.pix_valid_o  = pix_valid_r;
    assign bus.pix_x_o      = pix_x_r;
    assign bus.pix_y_o      = pix_y_r;
    assign bus.pix_color_o  = pix_color_r;
    assign bus.busy_o       = busy_r;
    assign bus.done_o       = done_r;

endmodule

// File: tb/tb_iso_line_raster.sv
// Scoreboard bench for iso_line_raster: stimulus pushes expected pixels, a monitor pops them.
module tb_iso_line_raster;
    import iso_pkg::*;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] c;
    } exp_pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    iso_line_raster_if bus();

    iso_line_raster dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int       cyc = 0;
    exp_pix_t expq[$];
    int       errors = 0;
    int       checks = 0;
    int       done_count = 0;
    int       hs_count = 0;
    int       last_hs_cyc = -10;
    bit       chk_adj = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int x, input int y, input int c);
        exp_pix_t e;
        e.x = 10'(x);
        e.y = 10'(y);
        e.c = 8'(c);
        expq.push_back(e);
    endtask

    // Monitor: every pixel handshake pops one expected pixel; done must find the queue empty.
    always @(negedge clk) begin
        exp_pix_t e;
        if (!rst) begin
            if (bus.pix_valid_o && bus.pix_ready_i) begin
                hs_count++;
                last_hs_cyc = cyc;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) expected none", bus.pix_x_o, bus.pix_y_o);
                end else begin
                    e = expq.pop_front();
                    if (bus.pix_x_o !== e.x || bus.pix_y_o !== e.y || bus.pix_color_o !== e.c) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                                 bus.pix_x_o, bus.pix_y_o, bus.pix_color_o, e.x, e.y, e.c);
                    end
                end
            end
            if (bus.done_o) begin
                done_count++;
                check("done_queue_empty", expq.size(), 0);
                if (chk_adj) check("done_after_last_pixel", cyc, last_hs_cyc + 1);
            end
        end
    end

    // Issue one segment and check the two-cycle latency to the first pixel.
    task automatic send(input int x0, input int y0, input int x1, input int y1, input int c);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        bus.x0_i = coord_t'(x0);
        bus.y0_i = coord_t'(y0);
        bus.x1_i = coord_t'(x1);
        bus.y1_i = coord_t'(y1);
        bus.color_i = color_t'(c);
        bus.line_valid_i = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.line_ready_o) got = 1'b1;
        end
        check("line_accepted", int'(got), 1);
        @(posedge clk); #1;
        bus.line_valid_i = 1'b0;
        @(negedge clk);
        check("latency_setup_no_pixel", int'(bus.pix_valid_o), 0);
        @(negedge clk);
        check("latency_first_pixel", int'(bus.pix_valid_o), 1);
    endtask

    task automatic wait_done(input int prev);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            if (done_count > prev) got = 1'b1;
        end
        check("done_seen", int'(got), 1);
    endtask

    initial begin
        int d0;
        int h0;
        int n_clip;
        bus.line_valid_i = 1'b0;
        bus.x0_i = '0;
        bus.y0_i = '0;
        bus.x1_i = '0;
        bus.y1_i = '0;
        bus.color_i = '0;
        bus.pix_ready_i = 1'b1;

        #12;
        check("rst_line_ready", int'(bus.line_ready_o), 1);
        check("rst_pix_valid", int'(bus.pix_valid_o), 0);
        check("rst_pix_x", int'(bus.pix_x_o), 0);
        check("rst_pix_y", int'(bus.pix_y_o), 0);
        check("rst_pix_color", int'(bus.pix_color_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Horizontal segment, free-running writer.
        for (int i = 0; i < 4; i++) push(320 + i, 240, 5);
        d0 = done_count;
        send(0, 0, 3, 0, 5);
        check("busy_in_run", int'(bus.busy_o), 1);
        check("ready_low_in_run", int'(bus.line_ready_o), 0);
        wait_done(d0);

        // Diagonal up-right: screen y decreases.
        push(320, 240, 9); push(321, 239, 9); push(322, 238, 9);
        d0 = done_count;
        send(0, 0, 2, 2, 9);
        wait_done(d0);

        // Steep segment, both steps negative.
        push(320, 240, 3); push(320, 239, 3); push(319, 238, 3); push(319, 237, 3);
        d0 = done_count;
        send(0, 0, -1, 3, 3);
        wait_done(d0);

        // Degenerate segment: one pixel, ready again two cycles after its handshake.
        push(325, 245, 7);
        d0 = done_count;
        send(5, -5, 5, -5, 7);
        @(negedge clk);
        check("degen_done_pulse", int'(bus.done_o), 1);
        check("degen_ready_low", int'(bus.line_ready_o), 0);
        @(negedge clk);
        check("degen_ready_back", int'(bus.line_ready_o), 1);
        check("degen_done_count", done_count - d0, 1);

        // Backpressure on the second pixel plus an ignored request during RUN.
        for (int i = 0; i < 4; i++) push(320 + i, 240, 5);
        d0 = done_count;
        h0 = hs_count;
        send(0, 0, 3, 0, 5);
        @(posedge clk); #1;
        bus.pix_ready_i = 1'b0;
        bus.x0_i = coord_t'(100);
        bus.y0_i = coord_t'(100);
        bus.x1_i = coord_t'(0);
        bus.y1_i = coord_t'(0);
        bus.color_i = color_t'(8'd99);
        bus.line_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", int'(bus.pix_valid_o), 1);
            check("stall_x", int'(bus.pix_x_o), 321);
            check("stall_y", int'(bus.pix_y_o), 240);
            check("stall_color", int'(bus.pix_color_o), 5);
        end
        @(posedge clk); #1;
        bus.pix_ready_i = 1'b1;
        bus.line_valid_i = 1'b0;
        wait_done(d0);
        check("stall_pixel_count", hs_count - h0, 4);
        repeat (3) @(negedge clk);
        check("ignored_request_idle", int'(bus.busy_o), 0);
        check("ignored_request_no_done", done_count - d0, 1);

        // Segment crossing the right screen edge.
`ifdef LINE_CLIP_EN
        n_clip = 20;
        chk_adj = 1'b0;
`else
        n_clip = 31;
`endif
        for (int i = 0; i < n_clip; i++) push(620 + i, 240, 2);
        d0 = done_count;
        h0 = hs_count;
        send(300, 0, 330, 0, 2);
        wait_done(d0);
        check("edge_pixel_count", hs_count - h0, n_clip);
        chk_adj = 1'b1;

        // Reset after the second pixel of a segment.
        for (int i = 0; i < 4; i++) push(320 + i, 240, 5);
        d0 = done_count;
        send(0, 0, 3, 0, 5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_pix_valid", int'(bus.pix_valid_o), 0);
        check("abort_busy", int'(bus.busy_o), 0);
        check("abort_line_ready", int'(bus.line_ready_o), 1);
        check("abort_pix_x", int'(bus.pix_x_o), 0);
        expq.delete();
        h0 = hs_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_count - d0, 0);
        check("abort_no_pixels", hs_count - h0, 0);
        check("abort_ready_after", int'(bus.line_ready_o), 1);

        push(320, 240, 9); push(321, 239, 9); push(322, 238, 9);
        d0 = done_count;
        send(0, 0, 2, 2, 9);
        wait_done(d0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
